rob_tracker: RTL and testbench

- In-order completion tracker (reorder buffer control) sitting directly downstream of the writeback arbiter.
- Allocates a ROB index per issued instruction and records completion or exception reported on the arbiter's completion outputs.
- Retires entries strictly in program order, one per cycle.
- When an excepting instruction reaches the head, it raises a precise exception and flushes all entries.

---
 rtl/params_pkg.sv | 31 +++
 rtl/rob_tracker.sv | 124 ++++++++++++
 tb/tb_rob_tracker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared core parameters and types, including the reorder-buffer entry layout.
package params_pkg;

    localparam int unsigned ROB_ENTRY_WIDTH = 3;
    localparam int unsigned ADDR_WIDTH      = 32;
    localparam int unsigned CAUSE_WIDTH     = 4;
    localparam int unsigned ROB_ENTRIES     = 2 ** ROB_ENTRY_WIDTH;

    typedef enum logic [CAUSE_WIDTH-1:0] {
        EXC_INSTR_MISALIGNED = 4'd0,
        EXC_INSTR_FAULT      = 4'd1,
        EXC_ILLEGAL_INSTR    = 4'd2,
        EXC_BREAKPOINT       = 4'd3,
        EXC_LOAD_MISALIGNED  = 4'd4,
        EXC_LOAD_FAULT       = 4'd5,
        EXC_STORE_MISALIGNED = 4'd6,
        EXC_STORE_FAULT      = 4'd7,
        EXC_ECALL_U          = 4'd8,
        EXC_ECALL_M          = 4'd11
    } excpt_cause_t;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  excpt;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] tval;
        excpt_cause_t          cause;
    } rob_entry_t;

endpackage

// File: rtl/rob_tracker.sv
// In-order completion tracker: allocates ROB slots at issue, records completions,
// retires one entry per cycle in program order and flushes on a precise exception.
module rob_tracker
    import params_pkg::excpt_cause_t;
    import params_pkg::rob_entry_t;
    import params_pkg::CAUSE_WIDTH;
#(
    parameter int unsigned ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
    parameter int unsigned ADDR_WIDTH      = params_pkg::ADDR_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_valid_i,
    input  logic [ADDR_WIDTH-1:0]      alloc_pc_i,
    output logic                       alloc_ready_o,
    output logic [ROB_ENTRY_WIDTH-1:0] alloc_idx_o,
    input  logic                       instr_is_completed_i,
    input  logic                       instr_with_excpt_i,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_idx_i,
    input  logic [ADDR_WIDTH-1:0]      instr_excpt_tval_i,
    input  excpt_cause_t               instr_excpt_cause_i,
    output logic                       commit_valid_o,
    output logic [ROB_ENTRY_WIDTH-1:0] commit_idx_o,
    output logic [ADDR_WIDTH-1:0]      commit_pc_o,
    output logic                       excpt_valid_o,
    output logic [ADDR_WIDTH-1:0]      excpt_pc_o,
    output logic [ADDR_WIDTH-1:0]      excpt_tval_o,
    output excpt_cause_t               excpt_cause_o,
    output logic                       flush_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned ENTRIES = 2 ** ROB_ENTRY_WIDTH;
    localparam int unsigned CW      = ROB_ENTRY_WIDTH + 1;

    rob_entry_t                 entries [ENTRIES];
    logic [ROB_ENTRY_WIDTH-1:0] head;
    logic [ROB_ENTRY_WIDTH-1:0] tail;
    logic [CW-1:0]              count;

    rob_entry_t head_e;
    logic       commit_fire;
    logic       excpt_fire;
    logic       alloc_fire;
    logic       complete_any;

    // Retire decisions and all outputs depend on registered state only.
    always_comb begin
        head_e         = entries[head];
        commit_fire    = head_e.valid && head_e.done && !head_e.excpt;
        excpt_fire     = head_e.valid && head_e.done && head_e.excpt;
        complete_any   = instr_is_completed_i || instr_with_excpt_i;

        full_o         = (count == CW'(ENTRIES));
        empty_o        = (count == CW'(0));
        alloc_ready_o  = !full_o && !excpt_fire;
        alloc_idx_o    = tail;
        alloc_fire     = alloc_valid_i && alloc_ready_o;

        commit_valid_o = commit_fire;
        commit_idx_o   = '0;
        commit_pc_o    = '0;
        excpt_valid_o  = excpt_fire;
        flush_o        = excpt_fire;
        excpt_pc_o     = '0;
        excpt_tval_o   = '0;
        excpt_cause_o  = excpt_cause_t'(CAUSE_WIDTH'(0));

        if (commit_fire) begin
            commit_idx_o = head;
            commit_pc_o  = head_e.pc;
        end
        if (excpt_fire) begin
            excpt_pc_o    = head_e.pc;
            excpt_tval_o  = head_e.tval;
            excpt_cause_o = head_e.cause;
        end
    end

    // Entry array and pointers; an exception at the head wipes everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else if (excpt_fire) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].done  <= 1'b0;
                entries[i].excpt <= 1'b0;
            end
        end else begin
            if (complete_any && entries[rob_idx_i].valid) begin
                entries[rob_idx_i].done  <= 1'b1;
                entries[rob_idx_i].excpt <= instr_with_excpt_i;
                if (instr_with_excpt_i) begin
                    entries[rob_idx_i].tval  <= instr_excpt_tval_i;
                    entries[rob_idx_i].cause <= instr_excpt_cause_i;
                end
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
                head                <= head + ROB_ENTRY_WIDTH'(1);
            end
            // Tail slot is never valid here: a full buffer blocks allocation.
            if (alloc_fire) begin
                entries[tail].valid <= 1'b1;
                entries[tail].done  <= 1'b0;
                entries[tail].excpt <= 1'b0;
                entries[tail].pc    <= alloc_pc_i;
                tail                <= tail + ROB_ENTRY_WIDTH'(1);
            end
            count <= count + CW'(alloc_fire) - CW'(commit_fire);
        end
    end

endmodule

// File: tb/tb_rob_tracker.sv
// Randomized bench for rob_tracker against a program-order queue model.
module tb_rob_tracker;
    import params_pkg::*;

    localparam int unsigned W = 3;
    localparam int unsigned A = 32;
    localparam int unsigned N = 2 ** W;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           alloc_valid = 1'b0;
    logic [A-1:0]   alloc_pc = '0;
    logic           alloc_ready;
    logic [W-1:0]   alloc_idx;
    logic           completed = 1'b0;
    logic           with_excpt = 1'b0;
    logic [W-1:0]   rob_idx = '0;
    logic [A-1:0]   tval_in = '0;
    excpt_cause_t   cause_in = EXC_INSTR_MISALIGNED;
    logic           commit_valid;
    logic [W-1:0]   commit_idx;
    logic [A-1:0]   commit_pc;
    logic           excpt_valid;
    logic [A-1:0]   excpt_pc;
    logic [A-1:0]   excpt_tval;
    excpt_cause_t   excpt_cause;
    logic           flush;
    logic           empty;
    logic           full;

    rob_tracker #(.ROB_ENTRY_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_pc_i(alloc_pc),
        .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
        .instr_is_completed_i(completed), .instr_with_excpt_i(with_excpt),
        .rob_idx_i(rob_idx), .instr_excpt_tval_i(tval_in),
        .instr_excpt_cause_i(cause_in),
        .commit_valid_o(commit_valid), .commit_idx_o(commit_idx), .commit_pc_o(commit_pc),
        .excpt_valid_o(excpt_valid), .excpt_pc_o(excpt_pc), .excpt_tval_o(excpt_tval),
        .excpt_cause_o(excpt_cause), .flush_o(flush),
        .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    // Pending instructions in program order; front is the oldest.
    typedef struct {
        int           idx;
        logic [A-1:0] pc;
        bit           done;
        bit           exc;
        logic [A-1:0] tval;
        excpt_cause_t cause;
    } ent_t;

    ent_t          q[$];
    int            tail_m = 0;
    bit            model_known = 0;
    logic [A-1:0]  commit_log[$];
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit av, input logic [A-1:0] pc, input bit comp, input bit exc,
                       input int idx, input logic [A-1:0] tv, input excpt_cause_t cs,
                       input bit do_rst);
        int  n;
        bit  ret_c, ret_e, full_m, ready_m;
        rst = do_rst; alloc_valid = av; alloc_pc = pc;
        completed = comp; with_excpt = exc; rob_idx = W'(idx);
        tval_in = tv; cause_in = cs;
        n       = q.size();
        ret_c   = n > 0 && q[0].done && !q[0].exc;
        ret_e   = n > 0 && q[0].done && q[0].exc;
        full_m  = (n == N);
        ready_m = !full_m && !ret_e;
        if (model_known) begin
            check("alloc_ready", 64'(alloc_ready), 64'(ready_m));
            check("alloc_idx", 64'(alloc_idx), 64'(tail_m));
            check("empty", 64'(empty), 64'(n == 0));
            check("full", 64'(full), 64'(full_m));
            check("commit_valid", 64'(commit_valid), 64'(ret_c));
            check("commit_idx", 64'(commit_idx), ret_c ? 64'(q[0].idx) : 64'(0));
            check("commit_pc", 64'(commit_pc), ret_c ? 64'(q[0].pc) : 64'(0));
            check("excpt_valid", 64'(excpt_valid), 64'(ret_e));
            check("flush", 64'(flush), 64'(ret_e));
            check("excpt_pc", 64'(excpt_pc), ret_e ? 64'(q[0].pc) : 64'(0));
            check("excpt_tval", 64'(excpt_tval), ret_e ? 64'(q[0].tval) : 64'(0));
            check("excpt_cause", 64'(excpt_cause), ret_e ? 64'(q[0].cause) : 64'(0));
        end
        if (do_rst) begin
            q.delete(); tail_m = 0; model_known = 1;
        end else if (ret_e) begin
            q.delete(); tail_m = 0;
        end else begin
            if (comp || exc) begin
                foreach (q[i]) begin
                    if (q[i].idx == idx) begin
                        q[i].done = 1;
                        q[i].exc  = exc;
                        if (exc) begin
                            q[i].tval  = tv;
                            q[i].cause = cs;
                        end
                    end
                end
            end
            if (ret_c) begin
                commit_log.push_back(q[0].pc);
                void'(q.pop_front());
            end
            if (av && ready_m) begin
                q.push_back('{idx: tail_m, pc: pc, done: 0, exc: 0, tval: '0,
                              cause: EXC_INSTR_MISALIGNED});
                tail_m = (tail_m + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0, '0, EXC_INSTR_MISALIGNED, 0);
    endtask
    task automatic alloc(input logic [A-1:0] pc);
        cyc(1, pc, 0, 0, 0, '0, EXC_INSTR_MISALIGNED, 0);
    endtask
    task automatic comp(input int idx);
        cyc(0, '0, 1, 0, idx, '0, EXC_INSTR_MISALIGNED, 0);
    endtask
    task automatic reset_dut();
        cyc(0, '0, 0, 0, 0, '0, EXC_INSTR_MISALIGNED, 1);
    endtask

    initial begin
        @(negedge clk);
        reset_dut();
        check("rst_ready", 64'(alloc_ready), 64'(1));
        check("rst_empty", 64'(empty), 64'(1));

        // In-order retirement despite reverse completion order
        commit_log.delete();
        alloc(32'h100); alloc(32'h104); alloc(32'h108);
        comp(2); comp(1); comp(0);
        repeat (4) idle();
        check("order_n", 64'(commit_log.size()), 64'(3));
        if (commit_log.size() == 3) begin
            check("order_0", 64'(commit_log[0]), 64'h100);
            check("order_1", 64'(commit_log[1]), 64'h104);
            check("order_2", 64'(commit_log[2]), 64'h108);
        end

        // Fill, overflow attempt, commit+alloc collision, then wrap
        reset_dut();
        for (int i = 0; i < N; i++) alloc(32'h200 + 32'(4 * i));
        check("fill_full", 64'(full), 64'(1));
        alloc(32'h2FC);
        comp(0);
        alloc(32'h2F0);
        check("wrap_idx", 64'(alloc_idx), 64'(0));
        alloc(32'h2F4);
        check("wrap_full", 64'(full), 64'(1));

        // Precise exception at the head flushes younger entries
        reset_dut();
        commit_log.delete();
        for (int i = 0; i < 4; i++) alloc(32'h300 + 32'(4 * i));
        cyc(0, '0, 0, 1, 1, 32'hDEAD, EXC_LOAD_FAULT, 0);
        comp(0);
        idle();
        check("exc_flush", 64'(flush), 64'(1));
        check("exc_tval", 64'(excpt_tval), 64'hDEAD);
        idle();
        check("post_exc_empty", 64'(empty), 64'(1));
        comp(2); comp(3); idle(); idle();
        check("post_exc_commits", 64'(commit_log.size()), 64'(1));

        // Reset with pending work, then a stale completion
        reset_dut();
        for (int i = 0; i < 5; i++) alloc(32'h400 + 32'(4 * i));
        comp(3); comp(4);
        reset_dut();
        check("midrst_empty", 64'(empty), 64'(1));
        comp(3);
        idle();
        check("midrst_no_commit", 64'(commit_valid), 64'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bit av, cp, ex, rs;
            av = ($urandom % 4) != 0;
            cp = ($urandom % 2) == 0;
            ex = ($urandom % 10) == 0;
            rs = ($urandom % 400) == 0;
            cyc(av, $urandom, cp, ex, $urandom_range(0, N - 1), $urandom,
                excpt_cause_t'(4'($urandom_range(0, 7))), rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
